lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: RV32I address generation, fault checking, byte-lane
// steering and load extension between a request/response core port and a 1-cycle data memory.
module lsu_ctrl #(
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  localparam logic [33:0] AddrLimit = 34'(DMEM_WORDS) << 2;

  localparam logic [1:0] FaultOk      = 2'b00;
  localparam logic [1:0] FaultMisalgn = 2'b01;
  localparam logic [1:0] FaultRange   = 2'b10;
  localparam logic [1:0] FaultIllegal = 2'b11;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] daddr_q;
  logic [31:0] dwdata_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_fault_q;

  logic [31:0] req_addr;
  logic        illegal, misaligned, out_of_range;
  logic [1:0]  fault;
  logic [31:0] wdata_rep;
  logic [3:0]  wmask;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign req_addr = req_base + req_offset;

  // Request decode; only meaningful in the accept cycle.
  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    fault        = FaultOk;
    wdata_rep    = req_wdata;
    if (req_store) begin
      illegal = (req_funct3 > 3'd2);
    end else begin
      illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr} >= AddrLimit);
    if (illegal) begin
      fault = FaultIllegal;
    end else if (misaligned) begin
      fault = FaultMisalgn;
    end else if (out_of_range) begin
      fault = FaultRange;
    end
    case (req_funct3[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Byte enables and load extension from the registered access.
  always_comb begin
    wmask    = 4'b1111;
    lane     = drdata >> {daddr_q[1:0], 3'b000};
    load_val = lane;
    case (funct3_q[1:0])
      2'b00:   wmask = 4'b0001 << daddr_q[1:0];
      2'b01:   wmask = daddr_q[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
    case (funct3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    we        = 4'b0000;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (fault != FaultOk) ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (store_q) begin
          we = wmask;
        end
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      funct3_q    <= 3'b000;
      store_q     <= 1'b0;
      daddr_q     <= 32'h0;
      dwdata_q    <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= FaultOk;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && req_valid) begin
        funct3_q <= req_funct3;
        store_q  <= req_store;
        if (fault == FaultOk) begin
          // Memory-facing registers move only for requests that will really access memory.
          daddr_q <= req_addr;
          if (req_store) begin
            dwdata_q <= wdata_rep;
          end
        end else begin
          rsp_fault_q <= fault;
          rsp_rdata_q <= 32'h0;
        end
      end
      if (state_q == StAccess) begin
        rsp_fault_q <= FaultOk;
        rsp_rdata_q <= store_q ? 32'h0 : load_val;
      end
    end
  end

  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
